// File: rtl/can_bit_timing.sv
// CAN bit-timing unit: tq prescaler, SYNC/SEG1/SEG2 sequencing, hard sync and resync.
// Define CAN_TRIPLE_SAMPLE_EN to take RX_S as a majority vote over the last three SEG1 ticks.
module can_bit_timing #(
    parameter int BRP   = 4,
    parameter int TSEG1 = 13,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic RX,
    input  logic hard_sync_en,
    output logic SP,
    output logic TP,
    output logic RX_S
);
    localparam int PW = $clog2(BRP);
    localparam int CW = $clog2(TSEG1 + SJW + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(BRP - 1);
    localparam logic [CW-1:0] SEG1_LAST  = CW'(TSEG1 - 1);
    localparam logic [CW-1:0] SEG2_LAST  = CW'(TSEG2 - 1);
    localparam logic [CW-1:0] TSEG2_C    = CW'(TSEG2);
    localparam logic [CW-1:0] SJW_C      = CW'(SJW);

    typedef enum logic [1:0] {ST_SYNC, ST_SEG1, ST_SEG2} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   ext_q, ext_d, ext_n;
    logic [CW-1:0]   shrt_q, shrt_d, shrt_n;
    logic            allow_q, allow_d, allow_n;
    logic            sp_q, sp_d, tp_q, tp_d, rxs_q, rxs_d;
    logic            s1_q, s2_q, s3_q;
    logic            tq_tick, edge_ok, hard, resync, seg1_end, seg2_end, sample;
    logic [CW-1:0]   rem;
`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0]      hist_q, hist_d;
`endif

    assign tq_tick = (presc_q == PRESC_LAST);
    // Only recessive->dominant edges after a recessive sample may move the bit grid.
    assign edge_ok = s3_q & ~s2_q & rxs_q;
    assign hard    = edge_ok & hard_sync_en;
    assign resync  = edge_ok & ~hard_sync_en & allow_q & (state_q != ST_SYNC);
    assign rem     = TSEG2_C - cnt_q;

`ifdef CAN_TRIPLE_SAMPLE_EN
    assign sample = (hist_q[0] & hist_q[1]) | (hist_q[0] & s2_q) | (hist_q[1] & s2_q);
`else
    assign sample = s2_q;
`endif

    always_comb begin
        ext_n   = ext_q;
        shrt_n  = shrt_q;
        allow_n = allow_q;
        if (resync) begin
            allow_n = 1'b0;
            if (state_q == ST_SEG1) begin
                ext_n = ((cnt_q + CW'(1)) < SJW_C) ? (cnt_q + CW'(1)) : SJW_C;
            end else if (rem <= SJW_C) begin
                shrt_n = SEG2_LAST - cnt_q;
            end else begin
                shrt_n = SJW_C;
            end
        end
    end

    assign seg1_end = (state_q == ST_SEG1) && tq_tick && (cnt_q >= SEG1_LAST + ext_n);
    assign seg2_end = (state_q == ST_SEG2) && tq_tick && (cnt_q >= SEG2_LAST - shrt_n);

    always_comb begin
        state_d = state_q;
        presc_d = tq_tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        ext_d   = ext_n;
        shrt_d  = shrt_n;
        allow_d = allow_n;
        sp_d    = 1'b0;
        tp_d    = 1'b0;
        rxs_d   = rxs_q;
`ifdef CAN_TRIPLE_SAMPLE_EN
        hist_d  = hist_q;
`endif
        if (hard) begin
            state_d = ST_SEG1;
            presc_d = '0;
            cnt_d   = '0;
            ext_d   = '0;
            shrt_d  = '0;
            allow_d = 1'b0;
        end else if (tq_tick) begin
            case (state_q)
                ST_SYNC: begin
                    state_d = ST_SEG1;
                    cnt_d   = '0;
                end
                ST_SEG1: begin
`ifdef CAN_TRIPLE_SAMPLE_EN
                    hist_d = {hist_q[0], s2_q};
`endif
                    if (seg1_end) begin
                        state_d = ST_SEG2;
                        cnt_d   = '0;
                        ext_d   = '0;
                        sp_d    = 1'b1;
                        rxs_d   = sample;
                        allow_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SEG2: begin
                    if (seg2_end) begin
                        state_d = ST_SYNC;
                        cnt_d   = '0;
                        shrt_d  = '0;
                        tp_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
            presc_q <= '0;
            cnt_q   <= '0;
            ext_q   <= '0;
            shrt_q  <= '0;
            allow_q <= 1'b1;
            sp_q    <= 1'b0;
            tp_q    <= 1'b0;
            rxs_q   <= 1'b1;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
`ifdef CAN_TRIPLE_SAMPLE_EN
            hist_q  <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            shrt_q  <= shrt_d;
            allow_q <= allow_d;
            sp_q    <= sp_d;
            tp_q    <= tp_d;
            rxs_q   <= rxs_d;
            s1_q    <= RX;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
`ifdef CAN_TRIPLE_SAMPLE_EN
            hist_q  <= hist_d;
`endif
        end
    end

    assign SP   = sp_q;
    assign TP   = tp_q;
    assign RX_S = rxs_q;
endmodule
